// File: rtl/data_memory_io_manager.sv
// -----------------------------------------------------------------------------
// data_memory_io_manager
//
// Purpose:
//   Owns the data address register, the on-chip data RAM and a bank of
//   memory-mapped I/O ports, all behind one decoded address space:
//      0 .. PORT_BASE-1                      : data RAM
//      PORT_BASE .. PORT_BASE+NUM_PORTS-1    : I/O port k = addr - PORT_BASE
//      anything else                         : unmapped (access error)
//   Reads have a fixed one-cycle latency, with a valid strobe. Writes and reads
//   always use the address held before the edge. An accepted access can
//   post-increment the address. Input pins pass through two-flop synchronisers.
//
// Parameters:
//   ADDR_W     address register / address space width
//   DATA_W     data word width
//   NUM_PORTS  number of I/O ports (1..16)
//   PORT_W     width of each port (<= DATA_W)
//   PORT_BASE  address of port 0; RAM depth is PORT_BASE words
//
// Ports:
//   clk               system clock, rising edge
//   rst               asynchronous active-high reset
//   in_addr_write_en  load in_addr into the address register
//   in_addr           new address value
//   in_auto_inc       post-increment the address after an accepted access
//   in_write_en       write request at the current address
//   in_read_en        read request at the current address
//   in_data           write data
//   in_port           external input pins, port k at [k*PORT_W +: PORT_W]
//   out_data          registered read data (held while out_data_valid=0)
//   out_data_valid    one-cycle strobe, out_data updated this cycle
//   out_port          latched output port values
//   out_addr          current address register
//   out_error         one-cycle strobe marking an illegal access
// -----------------------------------------------------------------------------
module data_memory_io_manager #(
   parameter int ADDR_W    = 10,
   parameter int DATA_W    = 8,
   parameter int NUM_PORTS = 4,
   parameter int PORT_W    = 4,
   parameter int PORT_BASE = 1008
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_addr_write_en,
   input  logic [ADDR_W-1:0]           in_addr,
   input  logic                        in_auto_inc,
   input  logic                        in_write_en,
   input  logic                        in_read_en,
   input  logic [DATA_W-1:0]           in_data,
   input  logic [NUM_PORTS*PORT_W-1:0] in_port,
   output logic [DATA_W-1:0]           out_data,
   output logic                        out_data_valid,
   output logic [NUM_PORTS*PORT_W-1:0] out_port,
   output logic [ADDR_W-1:0]           out_addr,
   output logic                        out_error
);

   localparam int PORTS_W = NUM_PORTS * PORT_W;
   localparam int RAM_AW  = (PORT_BASE > 1) ? $clog2(PORT_BASE) : 1;

   // Decode bounds carry one extra bit: PORT_BASE+NUM_PORTS may equal
   // 2^ADDR_W, which does not fit in ADDR_W bits.
   localparam logic [ADDR_W:0] PORT_LO = (ADDR_W+1)'(PORT_BASE);
   localparam logic [ADDR_W:0] PORT_HI = (ADDR_W+1)'(PORT_BASE + NUM_PORTS);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [ADDR_W-1:0]  addr_q;
   logic [PORTS_W-1:0] sync1_q;
   logic [PORTS_W-1:0] sync2_q;
   logic [PORTS_W-1:0] out_port_q;
   logic [DATA_W-1:0]  out_data_q;
   logic               valid_q;
   logic               error_q;
   logic [DATA_W-1:0]  ram [PORT_BASE];

   // ---------------------------------------------------------------------------
   // Decode of the pre-edge address
   // ---------------------------------------------------------------------------
   logic [ADDR_W:0]    addr_x;
   logic [ADDR_W-1:0]  port_off;
   logic [RAM_AW-1:0]  ram_idx;
   logic               is_ram;
   logic               is_port;
   logic               is_unmapped;

   assign addr_x      = {1'b0, addr_q};
   assign is_ram      = (addr_x < PORT_LO);
   assign is_port     = (addr_x >= PORT_LO) && (addr_x < PORT_HI);
   assign is_unmapped = !is_ram && !is_port;
   assign port_off    = addr_q - PORT_LO[ADDR_W-1:0];
   assign ram_idx     = addr_q[RAM_AW-1:0];

   // ---------------------------------------------------------------------------
   // Access qualification
   // ---------------------------------------------------------------------------
   logic               access;
   logic               wr_acc;
   logic               rd_acc;
   logic               error_d;
   logic [ADDR_W-1:0]  addr_d;
   logic [DATA_W-1:0]  rd_word;

   // A read that collides with a write is dropped; the write still goes ahead.
   assign access  = in_read_en | in_write_en;
   assign wr_acc  = in_write_en;
   assign rd_acc  = in_read_en & ~in_write_en;
   assign error_d = (in_read_en & in_write_en) | (access & is_unmapped);

   // Explicit load beats auto-increment. Erroring accesses still count as
   // accesses for the increment, so software can stream across holes.
   always_comb begin
      // NOTE: every signal assigned in a combinational block gets a default
      // first, so no path leaves it unassigned and no latch is inferred.
      addr_d = addr_q;
      if (in_addr_write_en) begin
         addr_d = in_addr;
      end else if (in_auto_inc && access) begin
         addr_d = addr_q + ADDR_W'(1);
      end
   end

   // Read mux: RAM word, synchronised port value zero-extended, or 0 when
   // the address is unmapped.
   always_comb begin
      rd_word = '0;
      if (is_ram) begin
         rd_word = ram[ram_idx];
      end else if (is_port) begin
         for (int k = 0; k < NUM_PORTS; k++) begin
            if (port_off == ADDR_W'(k)) begin
               rd_word[PORT_W-1:0] = sync2_q[k*PORT_W +: PORT_W];
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Data RAM
   // ---------------------------------------------------------------------------
   // NOTE: the RAM array is deliberately left out of the reset; resetting it
   // would turn a block RAM into a huge flop array. Its contents are undefined
   // until written.
   always_ff @(posedge clk) begin
      if (!rst && wr_acc && is_ram) begin
         ram[ram_idx] <= in_data;
      end
   end

   // ---------------------------------------------------------------------------
   // Registers with asynchronous reset
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments, so every
         // register samples pre-edge values and ordering within the block
         // does not matter.
         addr_q     <= '0;
         sync1_q    <= '0;
         sync2_q    <= '0;
         out_port_q <= '0;
         out_data_q <= '0;
         valid_q    <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         addr_q  <= addr_d;
         sync1_q <= in_port;
         sync2_q <= sync1_q;

         // Only the low PORT_W data bits reach the port; the rest are ignored.
         for (int k = 0; k < NUM_PORTS; k++) begin
            if (wr_acc && is_port && (port_off == ADDR_W'(k))) begin
               out_port_q[k*PORT_W +: PORT_W] <= in_data[PORT_W-1:0];
            end
         end

         valid_q <= rd_acc;
         if (rd_acc) begin
            out_data_q <= rd_word;
         end
         error_q <= error_d;
      end
   end

   assign out_data       = out_data_q;
   assign out_data_valid = valid_q;
   assign out_port       = out_port_q;
   assign out_addr       = addr_q;
   assign out_error      = error_q;

endmodule

// File: tb/tb_data_memory_io_manager.sv
// -----------------------------------------------------------------------------
// tb_data_memory_io_manager
//
// Directed bench for data_memory_io_manager with default parameters. Each
// access that should produce a strobe (valid and/or error) pushes its expected
// response into a scoreboard queue; a monitor on the falling edge pops and
// compares whenever the DUT strobes. Address and port outputs are checked
// directly by the stimulus process.
// -----------------------------------------------------------------------------
module tb_data_memory_io_manager;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 8;
   localparam int NP     = 4;
   localparam int PW     = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_addr_write_en;
   logic [ADDR_W-1:0] in_addr;
   logic              in_auto_inc;
   logic              in_write_en;
   logic              in_read_en;
   logic [DATA_W-1:0] in_data;
   logic [NP*PW-1:0]  in_port;
   logic [DATA_W-1:0] out_data;
   logic              out_data_valid;
   logic [NP*PW-1:0]  out_port;
   logic [ADDR_W-1:0] out_addr;
   logic              out_error;

   data_memory_io_manager dut (
      .clk              (clk),
      .rst              (rst),
      .in_addr_write_en (in_addr_write_en),
      .in_addr          (in_addr),
      .in_auto_inc      (in_auto_inc),
      .in_write_en      (in_write_en),
      .in_read_en       (in_read_en),
      .in_data          (in_data),
      .in_port          (in_port),
      .out_data         (out_data),
      .out_data_valid   (out_data_valid),
      .out_port         (out_port),
      .out_addr         (out_addr),
      .out_error        (out_error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   typedef struct {
      logic [DATA_W-1:0] data;
      logic              valid;
      logic              err;
      int                cyc;
   } exp_t;

   exp_t              sb[$];
   logic [DATA_W-1:0] last_data = '0;

   // Called right after the request edge: the strobe belongs to this cycle.
   task automatic expect_read(input logic [DATA_W-1:0] d, input logic err);
      exp_t e;
      e.data = d; e.valid = 1'b1; e.err = err; e.cyc = cyc;
      sb.push_back(e);
      last_data = d;
   endtask

   task automatic expect_error();
      exp_t e;
      e.data = last_data; e.valid = 1'b0; e.err = 1'b1; e.cyc = cyc;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (out_data_valid === 1'b1 || out_error === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_strobe", {30'd0, out_data_valid, out_error}, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("resp_cycle", cyc, e.cyc);
            check("resp_data", {24'd0, out_data}, {24'd0, e.data});
            check("resp_valid_err", {30'd0, out_data_valid, out_error}, {30'd0, e.valid, e.err});
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers: inputs change 1 time unit after the rising edge
   // ---------------------------------------------------------------------------
   task automatic idle_inputs();
      in_addr_write_en = 1'b0;
      in_addr          = '0;
      in_auto_inc      = 1'b0;
      in_write_en      = 1'b0;
      in_read_en       = 1'b0;
      in_data          = '0;
   endtask

   task automatic drive(input logic aw, input logic [ADDR_W-1:0] a, input logic inc,
                        input logic we, input logic re, input logic [DATA_W-1:0] d);
      in_addr_write_en = aw;
      in_addr          = a;
      in_auto_inc      = inc;
      in_write_en      = we;
      in_read_en       = re;
      in_data          = d;
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic load(input logic [ADDR_W-1:0] a);
      drive(1'b1, a, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   initial begin
      rst = 1'b1;
      in_port = '0;
      idle_inputs();
      idle(2);
      check("reset_addr", {22'd0, out_addr}, 32'h0);
      check("reset_data", {24'd0, out_data}, 32'h0);
      check("reset_port", {16'd0, out_port}, 32'h0);
      check("reset_strobes", {30'd0, out_data_valid, out_error}, 32'h0);
      rst = 1'b0;
      idle(1);

      // Auto-increment on a plain RAM write: RAM[0]=0x3C, addr 0 -> 1.
      drive(1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 8'h3C);
      check("autoinc_write_addr", {22'd0, out_addr}, 32'h001);

      // Load 0x005, write 0xA7, read back one cycle later.
      load(10'h005);
      check("load_addr", {22'd0, out_addr}, 32'h005);
      drive(1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 8'hA7);
      drive(1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 8'h00);
      expect_read(8'hA7, 1'b0);
      idle(2);

      // Port 1 write: only the low nibble lands, other slices stay 0.
      load(10'h3F1);
      drive(1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 8'hFC);
      check("port1_write", {16'd0, out_port}, 32'h0000_00C0);
      load(10'h3F3);
      drive(1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 8'h5A);
      check("port3_write", {16'd0, out_port}, 32'h0000_A0C0);

      // Input port 2 through the synchroniser, zero-extended on read.
      in_port = 16'h0900;
      idle(2);
      load(10'h3F2);
      drive(1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 8'h00);
      expect_read(8'h09, 1'b0);
      idle(1);

      // Unmapped write at the top of the space: error, no state change, wrap.
      drive(1'b1, 10'h3FF, 1'b1, 1'b0, 1'b0, 8'h00);
      check("load_top", {22'd0, out_addr}, 32'h3FF);
      drive(1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 8'h55);
      expect_error();
      check("wrap_addr", {22'd0, out_addr}, 32'h000);
      check("unmapped_write_port", {16'd0, out_port}, 32'h0000_A0C0);
      drive(1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 8'h00);
      expect_read(8'h3C, 1'b0);
      check("autoinc_read_addr", {22'd0, out_addr}, 32'h001);
      idle(1);

      // Unmapped read: data 0 with valid and error together.
      load(10'h3F8);
      drive(1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 8'h00);
      expect_read(8'h00, 1'b1);
      idle(1);

      // Collision at 0x010 plus a same-cycle load of 0x020.
      load(10'h020);
      drive(1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 8'h77);
      load(10'h010);
      drive(1'b1, 10'h020, 1'b0, 1'b1, 1'b1, 8'h33);
      expect_error();
      check("collide_load_addr", {22'd0, out_addr}, 32'h020);
      drive(1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 8'h00);
      expect_read(8'h77, 1'b0);
      load(10'h010);
      drive(1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 8'h00);
      expect_read(8'h33, 1'b0);
      idle(1);

      // Reset during a pending read: strobe cancelled, everything zero.
      in_read_en = 1'b1;
      @(negedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      idle_inputs();
      check("rst_mid_data", {24'd0, out_data}, 32'h0);
      check("rst_mid_port", {16'd0, out_port}, 32'h0);
      check("rst_mid_addr", {22'd0, out_addr}, 32'h0);
      check("rst_mid_strobes", {30'd0, out_data_valid, out_error}, 32'h0);
      idle(1);
      rst = 1'b0;
      last_data = '0;
      idle(3);

      check("scoreboard_drained", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/data_memory_io_manager.md
Name: data_memory_io_manager

Overview:
- Parametrised successor to the single-address-register memory manager.
- Owns the data address register, the on-chip data RAM and a bank of NUM_PORTS memory-mapped I/O ports behind one decoded address space.
- Adds synchronous address loading, optional post-access auto-increment, a registered read path with a valid strobe, input-port synchronisers and an access-error flag.
- Sits between the CPU datapath (address/data/enables) and the board-level port pins.

Parameters:
- ADDR_W, 10, width of the address register and address space.
- DATA_W, 8, data word width.
- NUM_PORTS, 4, number of I/O ports; must be 1..16.
- PORT_W, 4, width of each port; must be <= DATA_W.
- PORT_BASE, 1008 (0x3F0), first port address; RAM occupies 0..PORT_BASE-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- in_addr_write_en  input  1  load in_addr into the address register.
- in_addr  input  ADDR_W  new address value.
- in_auto_inc  input  1  post-increment the address register after an accepted access.
- in_write_en  input  1  write request at the current address.
- in_read_en  input  1  read request at the current address.
- in_data  input  DATA_W  write data.
- in_port  input  NUM_PORTS*PORT_W  external input pins; port k is at bits [k*PORT_W +: PORT_W].
- out_data  output  DATA_W  registered read data.
- out_data_valid  output  1  one-cycle strobe; out_data is updated this cycle.
- out_port  output  NUM_PORTS*PORT_W  latched output port values.
- out_addr  output  ADDR_W  current address register.
- out_error  output  1  one-cycle strobe marking an illegal access.

Behaviour:
- Reset (async, while rst=1): out_addr=0, out_data=0, out_data_valid=0, out_port=0, out_error=0, input synchronisers=0. RAM contents are not reset.
- Address register: loads in_addr on the rising edge when in_addr_write_en=1. A load takes priority over auto-increment in the same cycle.
- Access address: every access in a cycle uses the address register value before that edge's update, so a load and an access in the same cycle means the access goes to the old address.
- Decode:
  - addr < PORT_BASE: RAM.
  - PORT_BASE <= addr < PORT_BASE+NUM_PORTS: port index = addr-PORT_BASE.
  - Any other address: unmapped.
- Write (in_write_en=1):
  - RAM: word written at the edge.
  - Port: out_port slice takes in_data[PORT_W-1:0] at the edge, visible the next cycle; upper data bits are ignored.
  - Unmapped: no state change; out_error=1 for one cycle.
- Read (in_read_en=1, in_write_en=0):
  - Fixed latency of 1 cycle: out_data and out_data_valid=1 appear the cycle after the request edge.
  - RAM read returns the stored word.
  - Port read returns the synchronised input value, zero-extended to DATA_W.
  - Unmapped read returns 0, with out_data_valid=1 and out_error=1.
  - out_data holds its last value whenever out_data_valid=0.
- Simultaneous read and write: the write is performed, the read is dropped (no valid strobe), and out_error=1.
- Read after write to the same RAM address on consecutive cycles returns the new data; no stale forwarding hazard.
- Input synchronisers: two flop stages per port bit, so a pin change is visible to reads 2 cycles later.
- Auto-increment:
  - When in_auto_inc=1, in_addr_write_en=0 and an access is accepted (read, write, or both), the address becomes addr+1 modulo 2^ADDR_W; 2^ADDR_W-1 wraps to 0.
  - Erroring accesses still increment.
  - No access means no increment.
- Back-to-back accesses are allowed every cycle; there are no wait states.
- Reset asserted mid-read: the pending valid strobe is cancelled and out_data returns to 0.

Test Plan:
- Reset, load addr 0x005, write 0xA7, then read 0x005 -> out_data=0xA7 with out_data_valid high for exactly 1 cycle, 1 cycle after the read request; out_error stays 0.
- Load 0x3F1, write 0xFC -> out_port[7:4]=0xC next cycle; all other slices remain 0.
- Drive in_port slice 2 to 0x9, wait 2 cycles, load 0x3F2 and read -> out_data=0x09.
- Load 0x3FF with in_auto_inc=1, write 0x55 -> out_error pulse, no state change, out_addr wraps to 0x000. Then read with auto-inc -> out_data=RAM[0], out_addr=0x001.
- Assert in_read_en and in_write_en together at 0x010 with in_data=0x33 -> RAM[0x010]=0x33, no out_data_valid, out_error=1. In the same cycle assert in_addr_write_en=1 with in_addr=0x020 -> the access still hits 0x010 and out_addr=0x020.
- Issue a read, then assert rst on the following clock low phase -> out_data_valid never rises, and all outputs read 0 while rst=1.
